// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
//   size_e  : access size encoding carried on req_size
//   state_e : response FSM states
//   MMIO_*  : byte offsets of the MMIO registers inside the MMIO half
//   req_t   : one load/store request (address held at full 32-bit width)
//   rsp_t   : one registered response
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_ILL  = 2'd3
   } size_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

   localparam int unsigned MMIO_LEDG  = 32'h0;
   localparam int unsigned MMIO_LEDR  = 32'h4;
   localparam int unsigned MMIO_CYCLE = 32'h8;

   typedef struct packed {
      logic        we;
      size_e       size;
      logic        sign_ext;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

endpackage

// File: rtl/dmem_if.sv
// Load/store-unit <-> data-memory handshake bundle.
//   Request channel : req_valid/req_ready with req_we, req_size, req_signed,
//                     req_addr, req_wdata
//   Response channel: rsp_valid/rsp_ready with rsp_rdata, rsp_err
//   master modport  : the load/store unit side
//   slave modport   : the controller side
interface dmem_if #(
   parameter int ADDR_W = 12
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering between the 32-bit RAM word and the
// right-aligned load/store data.
//   size      in  access size
//   sign_ext  in  1 sign-extend loads, 0 zero-extend
//   lane      in  addr[1:0]
//   wdata     in  right-aligned store data
//   rword     in  addressed RAM word
//   be        out byte enables for the store
//   wdata_sh  out store data placed on its lanes
//   rdata_ext out extracted and extended load data
module dmem_lane_align
   import dmem_pkg::*;
(
   input  size_e       size,
   input  logic        sign_ext,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext
);

   logic [31:0] rd_byte_sh;
   logic [31:0] rd_half_sh;

   always_comb begin
      be         = 4'b0000;
      wdata_sh   = 32'h0;
      rdata_ext  = 32'h0;
      rd_byte_sh = rword >> {lane, 3'b000};
      rd_half_sh = rword >> {lane[1], 4'b0000};
      // Store data is replicated across lanes; the byte enables pick the one written.
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << lane;
            wdata_sh  = {4{wdata[7:0]}};
            rdata_ext = {{24{sign_ext & rd_byte_sh[7]}}, rd_byte_sh[7:0]};
         end
         SZ_HALF: begin
            be        = 4'b0011 << {lane[1], 1'b0};
            wdata_sh  = {2{wdata[15:0]}};
            rdata_ext = {{16{sign_ext & rd_half_sh[15]}}, rd_half_sh[15:0]};
         end
         SZ_WORD: begin
            be        = 4'b1111;
            wdata_sh  = wdata;
            rdata_ext = rword;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_memory_controller.sv
// Data-memory controller: on-chip RAM in the lower half of the address space,
// MMIO (LEDG, LEDR and optional cycle counter) in the upper half. One access
// outstanding, response registered one cycle after accept.
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset
//   bus   slave request/response channels (dmem_if)
//   ledg  out  LEDG register
//   ledr  out  LEDR register
// Build option: DMEM_CYCLE_CNT_EN adds a free-running 32-bit read-only
// counter at MMIO offset 0x8; without it that offset is undecoded.
//
// state   | meaning
// ST_IDLE | no response pending, request channel open
// ST_RESP | response presented, held until rsp_ready
module data_memory_controller
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int LEDG_W = 9,
   parameter int LEDR_W = 18
)(
   input  logic              clk,
   input  logic              rst_n,
   dmem_if.slave             bus,
   output logic [LEDG_W-1:0] ledg,
   output logic [LEDR_W-1:0] ledr
);

   localparam int IDX_W     = ADDR_W - 3;
   localparam int OFF_W     = ADDR_W - 1;
   localparam int MAX_WORDS = 1 << IDX_W;
   // Words beyond the RAM half can never be addressed, so the array is capped there.
   localparam int RAM_WORDS = (DEPTH < MAX_WORDS) ? DEPTH : MAX_WORDS;
   localparam int RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

   if (DATA_W != 32) begin : g_data_w_check
      $error("data_memory_controller: DATA_W must be 32");
   end

   state_e            state_q, state_d;
   rsp_t              rsp_q, rsp_d;
   logic [LEDG_W-1:0] ledg_q, ledg_d;
   logic [LEDR_W-1:0] ledr_q, ledr_d;

   logic              req_ready;
   logic              accept;
   size_e             size;
   logic              is_mmio;
   logic [IDX_W-1:0]  ram_idx;
   logic [RAM_AW-1:0] ram_addr;
   logic [OFF_W-1:0]  mmio_off;
   logic              size_ill, misalign, ram_oob;
   logic              hit_ledg, hit_ledr, hit_cycle;
   logic              mmio_err, acc_err;
   logic [3:0]        be;
   logic [31:0]       wdata_sh, rdata_ext, ram_word, mmio_rdata;
   logic              ram_we;

   logic [31:0]       mem_q [RAM_WORDS];

   assign size     = size_e'(bus.req_size);
   assign is_mmio  = bus.req_addr[ADDR_W-1];
   assign ram_idx  = bus.req_addr[ADDR_W-2:2];
   assign ram_addr = ram_idx[RAM_AW-1:0];
   assign mmio_off = bus.req_addr[OFF_W-1:0];
   assign ram_word = mem_q[ram_addr];

   assign size_ill = (size == SZ_ILL);
   assign misalign = ((size == SZ_HALF) && bus.req_addr[0]) ||
                     ((size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
   assign ram_oob  = (32'(ram_idx) >= 32'(DEPTH));
   assign hit_ledg = (mmio_off == OFF_W'(MMIO_LEDG));
   assign hit_ledr = (mmio_off == OFF_W'(MMIO_LEDR));

`ifdef DMEM_CYCLE_CNT_EN
   logic [31:0] cycle_q, cycle_d;

   assign hit_cycle = (mmio_off == OFF_W'(MMIO_CYCLE));
   assign cycle_d   = cycle_q + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cycle_q <= 32'h0;
      else        cycle_q <= cycle_d;
   end
`else
   assign hit_cycle = 1'b0;
`endif

   assign mmio_err = (size != SZ_WORD) || !(hit_ledg || hit_ledr || hit_cycle) ||
                     (bus.req_we && hit_cycle);
   assign acc_err  = size_ill || misalign || (is_mmio ? mmio_err : ram_oob);

   always_comb begin
      mmio_rdata = 32'h0;
      if (hit_ledg) mmio_rdata = 32'(ledg_q);
      if (hit_ledr) mmio_rdata = 32'(ledr_q);
`ifdef DMEM_CYCLE_CNT_EN
      // Counter value as it stands at the accept edge.
      if (hit_cycle) mmio_rdata = cycle_q;
`endif
   end

   dmem_lane_align u_lane_align (
      .size      (size),
      .sign_ext  (bus.req_signed),
      .lane      (bus.req_addr[1:0]),
      .wdata     (bus.req_wdata),
      .rword     (ram_word),
      .be        (be),
      .wdata_sh  (wdata_sh),
      .rdata_ext (rdata_ext)
   );

   assign req_ready = (state_q == ST_IDLE) || bus.rsp_ready;
   assign accept    = bus.req_valid && req_ready;

   always_comb begin
      state_d = state_q;
      rsp_d   = rsp_q;
      ledg_d  = ledg_q;
      ledr_d  = ledr_q;
      ram_we  = 1'b0;

      case (state_q)
         ST_IDLE: if (accept) state_d = ST_RESP;
         ST_RESP: begin
            if (accept)             state_d = ST_RESP;
            else if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         rsp_d.err   = acc_err;
         rsp_d.rdata = 32'h0;
         if (!acc_err) begin
            if (bus.req_we) begin
               if (is_mmio) begin
                  if (hit_ledg) ledg_d = bus.req_wdata[LEDG_W-1:0];
                  if (hit_ledr) ledr_d = bus.req_wdata[LEDR_W-1:0];
               end else begin
                  ram_we = 1'b1;
               end
            end else begin
               rsp_d.rdata = is_mmio ? mmio_rdata : rdata_ext;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rsp_q   <= '0;
         ledg_q  <= '0;
         ledr_q  <= '0;
      end else begin
         state_q <= state_d;
         rsp_q   <= rsp_d;
         ledg_q  <= ledg_d;
         ledr_q  <= ledr_d;
      end
   end

   // No reset on the array so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[ram_addr][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_rdata = rsp_q.rdata;
   assign bus.rsp_err   = rsp_q.err;
   assign ledg          = ledg_q;
   assign ledr          = ledr_q;

endmodule

// File: tb/tb_data_memory_controller.sv
module tb_data_memory_controller;

   localparam int AW    = 12;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [8:0]  ledg;
   logic [17:0] ledr;

   always #5 clk = ~clk;

   dmem_if #(.ADDR_W(AW)) bus ();

   data_memory_controller #(
      .ADDR_W (AW),
      .DATA_W (32),
      .DEPTH  (DEPTH),
      .LEDG_W (9),
      .LEDR_W (18)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .ledg  (ledg),
      .ledr  (ledr)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  ref_mem [DEPTH*4];
   logic [31:0] m_ledg, m_ledr;

   logic [31:0] rd, exp_rd, c0, c1, hold_rd;
   logic        er, exp_er;
   logic        r_we, r_sgn;
   logic [1:0]  r_sz;
   logic [11:0] r_a;
   logic [31:0] r_wd;
   int          sel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: byte-addressed memory plus LED registers, from the access rules.
   task automatic model(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [11:0] a, input logic [31:0] wd,
                        output logic [31:0] mrd, output logic mer);
      int          nb;
      logic [31:0] val;
      logic [63:0] mask;
      nb  = 1 << sz;
      mrd = 32'h0;
      mer = 1'b0;
      if (sz == 2'd3) mer = 1'b1;
      else if ((int'(a) % nb) != 0) mer = 1'b1;
      else if (a < 12'h800) begin
         if ((int'(a) / 4) >= DEPTH) mer = 1'b1;
         else if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
         end else begin
            val = 32'h0;
            for (int i = 0; i < nb; i++) val = val | (32'(ref_mem[int'(a) + i]) << (8*i));
            mask = (64'd1 << (8*nb)) - 64'd1;
            if (sgn && val[8*nb-1]) val = val | ~mask[31:0];
            mrd = val;
         end
      end else begin
         if (sz != 2'd2) mer = 1'b1;
         else if (a == 12'h800) begin
            if (we) m_ledg = wd & 32'h1FF; else mrd = m_ledg;
         end else if (a == 12'h804) begin
            if (we) m_ledr = wd & 32'h3FFFF; else mrd = m_ledr;
         end else mer = 1'b1;
      end
   endtask

   task automatic access(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [11:0] a, input logic [31:0] wd,
                         output logic [31:0] ord, output logic oer);
      int n;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = sz;
      bus.req_signed = sgn;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (n < 20) else begin
         errors++;
         $error("FAIL req_ready_timeout: got %0d cycles expected <20", n);
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("rsp_valid_after_accept", 32'(bus.rsp_valid), 32'd1);
      ord = bus.rsp_rdata;
      oer = bus.rsp_err;
   endtask

   task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [11:0] a, input logic [31:0] wd,
                       output logic [31:0] ord, output logic oer);
      logic [31:0] mrd;
      logic        mer;
      access(we, sz, sgn, a, wd, ord, oer);
      model(we, sz, sgn, a, wd, mrd, mer);
      chk({tag, "_rdata"}, ord, mrd);
      chk({tag, "_err"}, 32'(oer), 32'(mer));
      chk({tag, "_ledg"}, 32'(ledg), m_ledg);
      chk({tag, "_ledr"}, 32'(ledr), m_ledr);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b1;
      m_ledg         = 32'h0;
      m_ledr         = 32'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("reset_rsp_err",   32'(bus.rsp_err), 32'd0);
      chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
      chk("reset_ledg",      32'(ledg), 32'h0);
      chk("reset_ledr",      32'(ledr), 32'h0);

      // Fill RAM with known random words.
      for (int i = 0; i < DEPTH; i++)
         xact("fill", 1'b1, 2'd2, 1'b0, 12'(i*4), $urandom, rd, er);
      repeat (2) @(posedge clk);

      // Store then load, checking first-response latency from idle.
      @(negedge clk);
      chk("idle_before_accept", 32'(bus.rsp_valid), 32'd0);
      xact("st_word_010", 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, rd, er);
      chk("st_word_010_lit", 32'(er), 32'd0);
      xact("ld_word_010", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, rd, er);
      chk("ld_word_010_lit", rd, 32'hDEADBEEF);

      xact("st_byte_013", 1'b1, 2'd0, 1'b0, 12'h013, 32'h00000080, rd, er);
      xact("ld_sbyte_013", 1'b0, 2'd0, 1'b1, 12'h013, 32'h0, rd, er);
      chk("ld_sbyte_013_lit", rd, 32'hFFFFFF80);
      xact("ld_ubyte_013", 1'b0, 2'd0, 1'b0, 12'h013, 32'h0, rd, er);
      chk("ld_ubyte_013_lit", rd, 32'h00000080);
      xact("ld_word_010b", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, rd, er);
      chk("ld_word_010b_lit", rd, 32'h80ADBEEF);

      xact("ld_half_011", 1'b0, 2'd1, 1'b0, 12'h011, 32'h0, rd, er);
      chk("ld_half_011_err", 32'(er), 32'd1);
      xact("st_word_012", 1'b1, 2'd2, 1'b0, 12'h012, 32'h12345678, rd, er);
      chk("st_word_012_err", 32'(er), 32'd1);
      xact("ld_word_010c", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, rd, er);
      chk("ld_word_010c_lit", rd, 32'h80ADBEEF);
      xact("size3", 1'b0, 2'd3, 1'b0, 12'h010, 32'h0, rd, er);
      chk("size3_err", 32'(er), 32'd1);
      xact("ram_oob", 1'b1, 2'd2, 1'b0, 12'h400, 32'h0, rd, er);
      chk("ram_oob_err", 32'(er), 32'd1);

      xact("st_ledg", 1'b1, 2'd2, 1'b0, 12'h800, 32'h000001FF, rd, er);
      xact("st_ledr", 1'b1, 2'd2, 1'b0, 12'h804, 32'h0003FFFF, rd, er);
      chk("ledg_lit", 32'(ledg), 32'h1FF);
      chk("ledr_lit", 32'(ledr), 32'h3FFFF);
      xact("st_ledg_wide", 1'b1, 2'd2, 1'b0, 12'h800, 32'hFFFFFE55, rd, er);
      xact("ld_ledg", 1'b0, 2'd2, 1'b0, 12'h800, 32'h0, rd, er);
      chk("ld_ledg_lit", rd, 32'h00000055);
      xact("st_ledg_byte", 1'b1, 2'd0, 1'b0, 12'h800, 32'h0, rd, er);
      xact("ld_mmio_0c", 1'b0, 2'd2, 1'b0, 12'h80C, 32'h0, rd, er);
      chk("ld_mmio_0c_err", 32'(er), 32'd1);

      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_ledg", 32'(ledg), 32'h0);
      chk("async_rst_ledr", 32'(ledr), 32'h0);
      chk("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      m_ledg = 32'h0;
      m_ledr = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;

      // Stalled response, then back-to-back accepts.
      @(negedge clk);
      bus.rsp_ready  = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd2;
      bus.req_signed = 1'b0;
      bus.req_addr   = 12'h010;
      @(posedge clk);
      #1;
      chk("stall_first_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_first_rdata", bus.rsp_rdata, 32'h80ADBEEF);
      hold_rd       = bus.rsp_rdata;
      bus.req_addr  = 12'h014;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("stall_valid",     32'(bus.rsp_valid), 32'd1);
         chk("stall_rdata",     bus.rsp_rdata, hold_rd);
         chk("stall_err",       32'(bus.rsp_err), 32'd0);
         chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      end
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      #1;
      chk("unstall_req_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      model(1'b0, 2'd2, 1'b0, 12'h014, 32'h0, exp_rd, exp_er);
      chk("b2b_second_valid", 32'(bus.rsp_valid), 32'd1);
      chk("b2b_second_rdata", bus.rsp_rdata, exp_rd);
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b1;
      bus.req_addr   = 12'h013;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("b2b_third_valid", 32'(bus.rsp_valid), 32'd1);
      chk("b2b_third_rdata", bus.rsp_rdata, 32'hFFFFFF80);

`ifdef DMEM_CYCLE_CNT_EN
      access(1'b0, 2'd2, 1'b0, 12'h808, 32'h0, c0, er);
      chk("cycle_ld0_err", 32'(er), 32'd0);
      repeat (4) @(posedge clk);
      access(1'b0, 2'd2, 1'b0, 12'h808, 32'h0, c1, er);
      chk("cycle_ld1_err", 32'(er), 32'd0);
      chk("cycle_delta", c1 - c0, 32'd5);
      access(1'b1, 2'd2, 1'b0, 12'h808, 32'h1234, rd, er);
      chk("cycle_st_err", 32'(er), 32'd1);
      chk("cycle_st_rdata", rd, 32'h0);
`else
      access(1'b0, 2'd2, 1'b0, 12'h808, 32'h0, rd, er);
      chk("nocycle_ld_err", 32'(er), 32'd1);
      chk("nocycle_ld_rdata", rd, 32'h0);
      access(1'b1, 2'd2, 1'b0, 12'h808, 32'h1234, rd, er);
      chk("nocycle_st_err", 32'(er), 32'd1);
      c0 = 32'h0;
      c1 = 32'h0;
`endif

      // Randomised mix against the reference.
      for (int t = 0; t < 400; t++) begin
         r_we  = 1'($urandom_range(0, 1));
         r_sgn = 1'($urandom_range(0, 1));
         r_sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         r_wd  = $urandom;
         sel   = $urandom_range(0, 9);
         if (sel <= 6)      r_a = 12'($urandom_range(0, DEPTH*4 - 1));
         else if (sel == 7) r_a = 12'($urandom_range(DEPTH*4, 12'h7FF));
         else if (sel == 8) r_a = 12'h800 + 12'($urandom_range(0, 3) * 4 + ($urandom_range(0, 1) * 12));
         else               r_a = 12'h800 + 12'($urandom_range(0, 1) * 4);
         if (r_a == 12'h808) r_a = 12'h80C;
         if ($urandom_range(0, 4) != 0 && r_sz != 2'd3)
            r_a = r_a & ~12'((1 << r_sz) - 1);
         xact("rand", r_we, r_sz, r_sgn, r_a, r_wd, rd, er);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
